// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, ALU/mux selects, states.
package multicycle_control_pkg;

    // Opcodes (IR[31:26]) and the JR function code (IR[5:0])
    localparam logic [5:0] R_TYPE   = 6'h00;
    localparam logic [5:0] J        = 6'h02;
    localparam logic [5:0] JAL      = 6'h03;
    localparam logic [5:0] BEQ      = 6'h04;
    localparam logic [5:0] BNE      = 6'h05;
    localparam logic [5:0] ADDI     = 6'h08;
    localparam logic [5:0] ANDI     = 6'h0C;
    localparam logic [5:0] ORI      = 6'h0D;
    localparam logic [5:0] LUI      = 6'h0F;
    localparam logic [5:0] LW       = 6'h23;
    localparam logic [5:0] SW       = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // ALUOp encodings
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_ADDI  = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_AND   = 3'b110;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StREx     = 4'd6,
        StRWb     = 4'd7,
        StIEx     = 4'd8,
        StIWb     = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StJalWb   = 4'd12,
        StLuiWb   = 4'd13,
        StJrEx    = 4'd14,
        StTrap    = 4'd15
    } state_t;

    // States that wait on mem_ready and are therefore covered by the timeout
    function automatic logic isWaitState(state_t s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/handshake bundle between the multi-cycle controller and its datapath.
interface multicycle_control_if #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3
);
    logic [OP_W-1:0]    OP;
    logic [5:0]         Funct;
    logic               mem_ready;

    logic               PCWrite;
    logic               PCWriteCondEQ;
    logic               PCWriteCondNE;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic               JumpAndLink;
    logic               LoadUpperImmediate;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic [3:0]         state;
    logic               trap;

    // Controller side
    modport master (
        input  OP, Funct, mem_ready,
        output PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, JumpAndLink, LoadUpperImmediate,
               ALUSrcB, PCSource, ALUOp, state, trap
    );

    // Datapath side
    modport slave (
        output OP, Funct, mem_ready,
        input  PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, JumpAndLink, LoadUpperImmediate,
               ALUSrcB, PCSource, ALUOp, state, trap
    );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive memory wait cycles; flags the TIMEOUT-th one. TIMEOUT=0 never expires.
module multicycle_control_mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] countQ;

    // Wait-cycle counter; clear wins over enable so a state change always restarts it
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            countQ <= '0;
        end else if (enable) begin
            countQ <= countQ + CntW'(1);
        end
    end

    // countQ holds the waits already spent, so this cycle is the TIMEOUT-th wait
    assign expired = (TIMEOUT != 0) && enable && (countQ == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-memory multi-cycle MIPS datapath, with wait timeout and trap.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.master bus
);
    state_t stateQ;
    logic   trapQ;
    logic   timerEnable;
    logic   timerClear;
    logic   timerExpired;

    assign timerEnable = isWaitState(stateQ) && !bus.mem_ready;
    assign timerClear  = !timerEnable || timerExpired;

    multicycle_control_mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .enable (timerEnable),
        .expired(timerExpired)
    );

    // State sequencing and sticky trap flag
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StFetch;
            trapQ  <= 1'b0;
        end else begin
            unique case (stateQ)
                StFetch: begin
                    if (bus.mem_ready) begin
                        stateQ <= StDecode;
                    end else if (timerExpired) begin
                        stateQ <= StTrap;
                        trapQ  <= 1'b1;
                    end
                end
                StDecode: begin
                    case (bus.OP)
                        OP_W'(LW), OP_W'(SW):         stateQ <= StMemAddr;
                        OP_W'(R_TYPE):                stateQ <= (bus.Funct == FUNCT_JR) ? StJrEx
                                                                                        : StREx;
                        OP_W'(ADDI), OP_W'(ORI),
                        OP_W'(ANDI):                  stateQ <= StIEx;
                        OP_W'(BEQ), OP_W'(BNE):       stateQ <= StBranch;
                        OP_W'(J):                     stateQ <= StJump;
                        OP_W'(JAL):                   stateQ <= StJalWb;
                        OP_W'(LUI):                   stateQ <= StLuiWb;
                        default: begin
                            stateQ <= StTrap;
                            trapQ  <= 1'b1;
                        end
                    endcase
                end
                StMemAddr: stateQ <= (bus.OP == OP_W'(LW)) ? StMemRd : StMemWr;
                StMemRd: begin
                    if (bus.mem_ready) begin
                        stateQ <= StMemWb;
                    end else if (timerExpired) begin
                        stateQ <= StTrap;
                        trapQ  <= 1'b1;
                    end
                end
                StMemWr: begin
                    if (bus.mem_ready) begin
                        stateQ <= StFetch;
                    end else if (timerExpired) begin
                        stateQ <= StTrap;
                        trapQ  <= 1'b1;
                    end
                end
                StREx:    stateQ <= StRWb;
                StIEx:    stateQ <= StIWb;
                StMemWb, StRWb, StIWb, StBranch, StJump, StJalWb, StLuiWb, StJrEx:
                          stateQ <= StFetch;
                StTrap:   stateQ <= StTrap;
            endcase
        end
    end

    // Datapath controls decoded from the current state; only FETCH looks at mem_ready
    always_comb begin
        bus.PCWrite            = 1'b0;
        bus.PCWriteCondEQ      = 1'b0;
        bus.PCWriteCondNE      = 1'b0;
        bus.IorD               = 1'b0;
        bus.MemRead            = 1'b0;
        bus.MemWrite           = 1'b0;
        bus.IRWrite            = 1'b0;
        bus.MemtoReg           = 1'b0;
        bus.RegDst             = 1'b0;
        bus.RegWrite           = 1'b0;
        bus.ALUSrcA            = 1'b0;
        bus.JumpAndLink        = 1'b0;
        bus.LoadUpperImmediate = 1'b0;
        bus.ALUSrcB            = SRCB_REG;
        bus.PCSource           = PCSRC_ALU;
        bus.ALUOp              = ALUOP_W'(ALUOP_ADD);
        unique case (stateQ)
            StFetch: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            StDecode: bus.ALUSrcB = SRCB_IMM_SH2;
            StMemAddr: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
            end
            StMemRd: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            StMemWb: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            StMemWr: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            StREx: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALUOP_W'(ALUOP_RTYPE);
            end
            StRWb: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            StIEx: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                if (bus.OP == OP_W'(ORI)) begin
                    bus.ALUOp = ALUOP_W'(ALUOP_OR);
                end else if (bus.OP == OP_W'(ANDI)) begin
                    bus.ALUOp = ALUOP_W'(ALUOP_AND);
                end else begin
                    bus.ALUOp = ALUOP_W'(ALUOP_ADDI);
                end
            end
            StIWb: bus.RegWrite = 1'b1;
            StBranch: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALUOp         = ALUOP_W'(ALUOP_SUB);
                bus.PCSource      = PCSRC_ALUOUT;
                bus.PCWriteCondEQ = (bus.OP == OP_W'(BEQ));
                bus.PCWriteCondNE = (bus.OP == OP_W'(BNE));
            end
            StJump: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_JUMP;
            end
            StJalWb: begin
                bus.RegWrite    = 1'b1;
                bus.JumpAndLink = 1'b1;
                bus.PCWrite     = 1'b1;
                bus.PCSource    = PCSRC_JUMP;
            end
            StLuiWb: begin
                bus.RegWrite           = 1'b1;
                bus.LoadUpperImmediate = 1'b1;
            end
            StJrEx: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_REGA;
            end
            StTrap: begin
            end
        endcase
    end

    assign bus.state = stateQ;
    assign bus.trap  = trapQ;

endmodule
